// File: rtl/i2s_dac_tx_if.sv
// i2s_dac_tx_if
//   Sample-side link between the volume mixer and the I2S DAC transmitter.
//
//   Handshake: the mixer pushes one stereo pair by raising sample_strobe for a
//   single clock with l_in/r_in valid in that clock. There is no backpressure;
//   the transmitter always accepts the pair. sample_req is a one-clock pulse
//   from the transmitter saying the held pair has just been consumed into the
//   serializer, which is the mixer's cue to deliver the next pair.
//
//   Signals:
//     l_in, r_in     mixer -> DAC   left/right sample, two's complement
//     sample_strobe  mixer -> DAC   one-clock push pulse
//     sample_req     DAC -> mixer   one-clock consume pulse
interface i2s_dac_tx_if #(
  parameter int AUD_BIT_DEPTH = 24
);
  logic [AUD_BIT_DEPTH-1:0] l_in;
  logic [AUD_BIT_DEPTH-1:0] r_in;
  logic                     sample_strobe;
  logic                     sample_req;

  modport master (
    output l_in,
    output r_in,
    output sample_strobe,
    input  sample_req
  );

  modport slave (
    input  l_in,
    input  r_in,
    input  sample_strobe,
    output sample_req
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx
//   Serializes stereo sample pairs from the volume mixer into a Philips I2S
//   stream for the codec DAC. Each pushed pair lands in a holding register and
//   is moved into a left/right shift pair at the start of every I2S frame.
//   BCLK and LRCK are derived from the system clock; sticky flags report
//   overrun (mixer faster than DAC) and underrun (DAC faster than mixer).
//
//   Ports:
//     sCLK_XVXENVS  in   system clock, rising edge
//     reset_reg_N   in   synchronous active-low reset
//     mix           if   sample push (l_in, r_in, sample_strobe) / sample_req
//     clr_flags     in   clears underrun/overrun (a same-clock set wins)
//     AUD_BCLK      out  bit clock, period 2*BCLK_DIV clocks
//     AUD_DACLRCK   out  word select, 0 = left slot, 1 = right slot
//     AUD_DACDAT    out  serial data, MSB first, one BCLK after LRCK edge
//     underrun      out  sticky: a frame started without a fresh sample
//     overrun       out  sticky: a fresh sample was replaced before use
module i2s_dac_tx #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 4
) (
  input  logic        sCLK_XVXENVS,
  input  logic        reset_reg_N,
  i2s_dac_tx_if.slave mix,
  input  logic        clr_flags,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        underrun,
  output logic        overrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam int DW         = $clog2(BCLK_DIV);

  localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] SLOT_LEN  = CW'(SLOT_BITS);
  localparam logic [CW-1:0] DEPTH     = CW'(AUD_BIT_DEPTH);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);

  logic [DW-1:0]            div_cnt;
  logic [CW-1:0]            bit_cnt;
  logic [AUD_BIT_DEPTH-1:0] hold_l, hold_r;
  logic [AUD_BIT_DEPTH-1:0] sh_l, sh_r;
  logic                     holding_full;

  logic          div_tc;
  logic          fall_tick;
  logic [CW-1:0] bit_nxt;
  logic          right_nxt;
  logic [CW-1:0] pos_nxt;
  logic          frame_load;
  logic          data_slot;

  // All serial state advances on the clock where BCLK is about to fall, so
  // LRCK/DACDAT are stable across every BCLK rising edge seen by the codec.
  always_comb begin
    div_tc     = (div_cnt == DIV_LAST);
    fall_tick  = div_tc && AUD_BCLK;
    bit_nxt    = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
    right_nxt  = (bit_nxt >= SLOT_LEN);
    pos_nxt    = right_nxt ? (bit_nxt - SLOT_LEN) : bit_nxt;
    frame_load = fall_tick && (bit_nxt == '0);
    // Slot position 0 is the one-BCLK I2S delay; positions past the sample
    // width are zero padding.
    data_slot  = (pos_nxt != '0) && (pos_nxt <= DEPTH);
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (!reset_reg_N) begin
      div_cnt        <= '0;
      bit_cnt        <= LAST_BIT;
      hold_l         <= '0;
      hold_r         <= '0;
      sh_l           <= '0;
      sh_r           <= '0;
      holding_full   <= 1'b0;
      AUD_BCLK       <= 1'b0;
      AUD_DACLRCK    <= 1'b0;
      AUD_DACDAT     <= 1'b0;
      mix.sample_req <= 1'b0;
      underrun       <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + DW'(1);
      if (div_tc) AUD_BCLK <= ~AUD_BCLK;

      mix.sample_req <= frame_load;

      if (fall_tick) begin
        bit_cnt     <= bit_nxt;
        AUD_DACLRCK <= right_nxt;
        if (frame_load) begin
          // Holding is never cleared on load, so an empty holding register
          // simply repeats the last pair.
          sh_l       <= hold_l;
          sh_r       <= hold_r;
          AUD_DACDAT <= 1'b0;
        end else if (data_slot) begin
          if (right_nxt) begin
            AUD_DACDAT <= sh_r[AUD_BIT_DEPTH-1];
            sh_r       <= sh_r << 1;
          end else begin
            AUD_DACDAT <= sh_l[AUD_BIT_DEPTH-1];
            sh_l       <= sh_l << 1;
          end
        end else begin
          AUD_DACDAT <= 1'b0;
        end
      end

      // A strobe in the load clock: the load above takes the old pair, the
      // holding register takes the new one and stays full.
      if (mix.sample_strobe) begin
        hold_l       <= mix.l_in;
        hold_r       <= mix.r_in;
        holding_full <= 1'b1;
      end else if (frame_load) begin
        holding_full <= 1'b0;
      end

      if (frame_load && !holding_full) underrun <= 1'b1;
      else if (clr_flags)              underrun <= 1'b0;

      if (mix.sample_strobe && holding_full && !frame_load) overrun <= 1'b1;
      else if (clr_flags)                                   overrun <= 1'b0;
    end
  end

endmodule
